// File: rtl/counter_snapshot_serializer_pkg.sv
// Shared constants for the counter snapshot serializer and the counter blocks it reads.
package counter_snapshot_serializer_pkg;

  localparam int SNAP_CNT_W = 128;
  localparam int SNAP_OUT_W = 16;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_SEND = 1'b1
  } snap_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_snapshot_serializer.sv
// Captures a wide counter atomically and streams it out as narrow words over valid/ready.
module counter_snapshot_serializer
  import counter_snapshot_serializer_pkg::*;
#(
  parameter int CNT_W     = SNAP_CNT_W,
  parameter int OUT_W     = SNAP_OUT_W,
  parameter int MSB_FIRST = 0,
  localparam int NUM_WORDS = CNT_W / OUT_W,
  localparam int IDX_W     = (clog2(NUM_WORDS) < 1) ? 1 : clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic             req_dropped,
  output logic             busy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  snap_state_e      state_q, state_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             snap_ack_q, snap_ack_d;
  logic             req_dropped_q, req_dropped_d;

  logic             last_w;
  logic [IDX_W-1:0] sel_w;
  logic [OUT_W-1:0] data_w;

  assign last_w = (idx_q == LAST_IDX);

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    idx_d         = idx_q;
    snap_ack_d    = 1'b0;
    req_dropped_d = 1'b0;
    case (state_q)
      SNAP_IDLE: begin
        if (snap_req) begin
          snap_d     = count_in;
          idx_d      = '0;
          state_d    = SNAP_SEND;
          snap_ack_d = 1'b1;
        end
      end
      SNAP_SEND: begin
        if (out_ready && last_w) begin
          // A request landing on the final transfer chains a new snapshot with no bubble.
          idx_d = '0;
          if (snap_req) begin
            snap_d     = count_in;
            snap_ack_d = 1'b1;
          end else begin
            state_d = SNAP_IDLE;
          end
        end else begin
          if (out_ready) begin
            idx_d = idx_q + IDX_W'(1);
          end
          req_dropped_d = snap_req;
        end
      end
      default: state_d = SNAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SNAP_IDLE;
      snap_q        <= '0;
      idx_q         <= '0;
      snap_ack_q    <= 1'b0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      idx_q         <= idx_d;
      snap_ack_q    <= snap_ack_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  assign sel_w = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;

  always_comb begin
    data_w = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (sel_w == IDX_W'(k)) begin
        data_w = snap_q[k*OUT_W +: OUT_W];
      end
    end
  end

  assign busy        = (state_q == SNAP_SEND);
  assign out_valid   = (state_q == SNAP_SEND);
  assign out_last    = (state_q == SNAP_SEND) && last_w;
  assign out_idx     = idx_q;
  assign out_data    = data_w;
  assign snap_ack    = snap_ack_q;
  assign req_dropped = req_dropped_q;

endmodule
